// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer: FSM states, edited field,
// field limits and small arithmetic helpers.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_e;

    typedef enum logic {
        FLD_MIN = 1'b0,
        FLD_SEC = 1'b1
    } field_e;

    localparam logic [5:0] UNIT_MAX = 6'd59;
    localparam logic [6:0] CS_MAX   = 7'd99;

    function automatic logic [5:0] unit_inc(input logic [5:0] v);
        unit_inc = (v >= UNIT_MAX) ? 6'd0 : v + 6'd1;
    endfunction

    // Centiseconds saturate at 59 so they fit the 6-bit number drivers.
    function automatic logic [5:0] clamp_cs(input logic [6:0] cc);
        clamp_cs = (cc > {1'b0, UNIT_MAX}) ? UNIT_MAX : cc[5:0];
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Button inputs and LED/status outputs of the countdown timer, grouped as one bundle.
interface countdown_timer_if;
    logic       btn_start;
    logic       btn_field;
    logic       btn_inc;
    logic [5:0] led_num0;
    logic [5:0] led_num1;
    logic       led_dot;
    logic       alarm;
    logic       running;

    modport master (
        output btn_start, btn_field, btn_inc,
        input  led_num0, led_num1, led_dot, alarm, running
    );

    modport slave (
        input  btn_start, btn_field, btn_inc,
        output led_num0, led_num1, led_dot, alarm, running
    );
endinterface

// File: rtl/countdown_timer_chain.sv
// MM:SS:CC count registers with preset load and decrement-with-borrow; exposes the
// next count so the top level can register its display in the same edge.
module countdown_chain
    import countdown_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_load,
    input  logic [5:0] i_load_mm,
    input  logic [5:0] i_load_ss,
    input  logic       i_dec,
    output logic [5:0] o_mm_nxt,
    output logic [5:0] o_ss_nxt,
    output logic [6:0] o_cc_nxt,
    output logic       o_is_zero,
    output logic       o_is_last
);

    logic [5:0] r_mm;
    logic [5:0] r_ss;
    logic [6:0] r_cc;

    assign o_is_zero = (r_mm == 6'd0) && (r_ss == 6'd0) && (r_cc == 7'd0);
    assign o_is_last = (r_mm == 6'd0) && (r_ss == 6'd0) && (r_cc == 7'd1);

    // Next count: load wins, decrement never underflows past zero.
    always_comb begin
        o_mm_nxt = r_mm;
        o_ss_nxt = r_ss;
        o_cc_nxt = r_cc;
        if (i_load) begin
            o_mm_nxt = i_load_mm;
            o_ss_nxt = i_load_ss;
            o_cc_nxt = 7'd0;
        end else if (i_dec && !o_is_zero) begin
            if (r_cc != 7'd0) begin
                o_cc_nxt = r_cc - 7'd1;
            end else begin
                o_cc_nxt = CS_MAX;
                if (r_ss != 6'd0) begin
                    o_ss_nxt = r_ss - 6'd1;
                end else begin
                    o_ss_nxt = UNIT_MAX;
                    o_mm_nxt = r_mm - 6'd1;
                end
            end
        end else begin
            o_cc_nxt = r_cc;
        end
    end

    // Count registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mm <= 6'd0;
            r_ss <= 6'd0;
            r_cc <= 7'd0;
        end else begin
            r_mm <= o_mm_nxt;
            r_ss <= o_ss_nxt;
            r_cc <= o_cc_nxt;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer top: FSM, prescaler, preset registers, display mux and alarm.
// Optional alarm blinking is built when COUNTDOWN_ALARM_BLINK_EN is defined.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 5000,
    parameter int BLINK_CS = 50
) (
    input  logic               clock,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    localparam int PW = $clog2(TICK_DIV);

    state_e        r_state;
    state_e        w_state_nxt;
    field_e        r_field;
    field_e        w_field_nxt;
    logic [5:0]    r_pre_mm;
    logic [5:0]    r_pre_ss;
    logic [5:0]    w_pre_mm_nxt;
    logic [5:0]    w_pre_ss_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic          w_presc_run;
    logic          w_tick;
    logic [5:0]    w_mm_nxt;
    logic [5:0]    w_ss_nxt;
    logic [6:0]    w_cc_nxt;
    logic          w_zero;
    logic          w_last;
    logic          w_alarm_on;
    logic          w_alarm_dot;
    logic [5:0]    w_led0_d;
    logic [5:0]    w_led1_d;
    logic          w_dot_d;
    logic [5:0]    r_led0;
    logic [5:0]    r_led1;
    logic          r_dot;
    logic          r_alarm;
    logic          r_running;

`ifdef COUNTDOWN_ALARM_BLINK_EN
    localparam int BW = (BLINK_CS > 1) ? $clog2(BLINK_CS) : 1;

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_ph;

    assign w_presc_run = (r_state == ST_RUN) || (r_state == ST_ALARM);
    assign w_alarm_on  = (w_state_nxt == ST_ALARM) && (r_state == ST_ALARM) && r_blink_ph;
    assign w_alarm_dot = w_alarm_on;

    // Blink phase: starts high on ALARM entry, flips every BLINK_CS ticks.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_blink_cnt <= {BW{1'b0}};
            r_blink_ph  <= 1'b0;
        end else if (r_state != ST_ALARM) begin
            r_blink_cnt <= {BW{1'b0}};
            r_blink_ph  <= 1'b1;
        end else if (w_tick) begin
            if (r_blink_cnt == BW'(BLINK_CS - 1)) begin
                r_blink_cnt <= {BW{1'b0}};
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + {{(BW-1){1'b0}}, 1'b1};
            end
        end else begin
            r_blink_cnt <= r_blink_cnt;
        end
    end
`else
    assign w_presc_run = (r_state == ST_RUN);
    assign w_alarm_on  = (w_state_nxt == ST_ALARM) && (r_state == ST_ALARM);
    assign w_alarm_dot = 1'b0;

    if (BLINK_CS < 1) begin : g_blink_cs_unused
    end
`endif

    assign w_tick = w_presc_run && (r_presc == PW'(TICK_DIV - 1));

    countdown_chain u_chain (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_state_nxt == ST_SET),
        .i_load_mm (w_pre_mm_nxt),
        .i_load_ss (w_pre_ss_nxt),
        .i_dec     (w_tick && (r_state == ST_RUN)),
        .o_mm_nxt  (w_mm_nxt),
        .o_ss_nxt  (w_ss_nxt),
        .o_cc_nxt  (w_cc_nxt),
        .o_is_zero (w_zero),
        .o_is_last (w_last)
    );

    // Next state, edited field and preset; start > field > inc.
    always_comb begin
        w_state_nxt  = r_state;
        w_field_nxt  = r_field;
        w_pre_mm_nxt = r_pre_mm;
        w_pre_ss_nxt = r_pre_ss;
        case (r_state)
            ST_SET: begin
                if (bus.btn_start) begin
                    if ((r_pre_mm != 6'd0) || (r_pre_ss != 6'd0)) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_SET;
                    end
                end else if (bus.btn_field) begin
                    w_field_nxt = (r_field == FLD_MIN) ? FLD_SEC : FLD_MIN;
                end else if (bus.btn_inc) begin
                    if (r_field == FLD_MIN) begin
                        w_pre_mm_nxt = unit_inc(r_pre_mm);
                    end else begin
                        w_pre_ss_nxt = unit_inc(r_pre_ss);
                    end
                end else begin
                    w_state_nxt = ST_SET;
                end
            end
            ST_RUN: begin
                if ((w_tick && w_last) || w_zero) begin
                    w_state_nxt = ST_ALARM;
                end else if (bus.btn_start) begin
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (bus.btn_start) begin
                    w_state_nxt = ST_RUN;
                end else if (bus.btn_field) begin
                    w_state_nxt = ST_SET;
                end else begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_ALARM: begin
                if (bus.btn_start || bus.btn_field) begin
                    w_state_nxt = ST_SET;
                end else begin
                    w_state_nxt = ST_ALARM;
                end
            end
            default: begin
                w_state_nxt = ST_SET;
            end
        endcase
    end

    // Prescaler: cleared in SET, held while paused (or frozen in a steady alarm).
    always_comb begin
        w_presc_nxt = r_presc;
        if (w_state_nxt == ST_SET) begin
            w_presc_nxt = {PW{1'b0}};
        end else if (w_presc_run) begin
            w_presc_nxt = w_tick ? {PW{1'b0}} : r_presc + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            w_presc_nxt = r_presc;
        end
    end

    // Display mux computed from next-state values so outputs track in one clock.
    always_comb begin
        w_led0_d = 6'd0;
        w_led1_d = 6'd0;
        w_dot_d  = 1'b0;
        case (w_state_nxt)
            ST_SET: begin
                w_led0_d = w_mm_nxt;
                w_led1_d = w_ss_nxt;
                w_dot_d  = (w_field_nxt == FLD_SEC);
            end
            ST_RUN, ST_PAUSE: begin
                if (w_mm_nxt != 6'd0) begin
                    w_led0_d = w_mm_nxt;
                    w_led1_d = w_ss_nxt;
                end else begin
                    w_led0_d = w_ss_nxt;
                    w_led1_d = clamp_cs(w_cc_nxt);
                end
                w_dot_d = (w_mm_nxt != 6'd0);
            end
            ST_ALARM: begin
                w_dot_d = w_alarm_dot;
            end
            default: begin
                w_dot_d = 1'b0;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_SET;
            r_field  <= FLD_MIN;
            r_pre_mm <= 6'd0;
            r_pre_ss <= 6'd0;
            r_presc  <= {PW{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_field  <= w_field_nxt;
            r_pre_mm <= w_pre_mm_nxt;
            r_pre_ss <= w_pre_ss_nxt;
            r_presc  <= w_presc_nxt;
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_led0    <= 6'd0;
            r_led1    <= 6'd0;
            r_dot     <= 1'b0;
            r_alarm   <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_led0    <= w_led0_d;
            r_led1    <= w_led1_d;
            r_dot     <= w_dot_d;
            r_alarm   <= w_alarm_on;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    assign bus.led_num0 = r_led0;
    assign bus.led_num1 = r_led1;
    assign bus.led_dot  = r_dot;
    assign bus.alarm    = r_alarm;
    assign bus.running  = r_running;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with TICK_DIV = 4, BLINK_CS = 2.
module tb_countdown_timer;
    import countdown_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    countdown_timer_if bus_if();

    countdown_timer #(.TICK_DIV(4), .BLINK_CS(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_disp(input string tag, input int e0, input int e1, input int edot);
        check_value({tag, ".led0"}, 32'(bus_if.led_num0), 32'(e0));
        check_value({tag, ".led1"}, 32'(bus_if.led_num1), 32'(e1));
        check_value({tag, ".dot"},  32'(bus_if.led_dot),  32'(edot));
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drives one cycle of buttons from a negedge; returns at the next negedge.
    task automatic press(input logic s, input logic f, input logic i);
        bus_if.btn_start = s;
        bus_if.btn_field = f;
        bus_if.btn_inc   = i;
        @(negedge clock);
        bus_if.btn_start = 1'b0;
        bus_if.btn_field = 1'b0;
        bus_if.btn_inc   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
    endtask

    initial begin
        int exp_alarm;
        int exp_dot;
        bus_if.btn_start = 1'b0;
        bus_if.btn_field = 1'b0;
        bus_if.btn_inc   = 1'b0;
        do_reset();
        check_disp("reset", 0, 0, 0);
        check_value("reset.alarm", 32'(bus_if.alarm), 32'd0);
        check_value("reset.running", 32'(bus_if.running), 32'd0);
        check_value("reset.state", 32'(dut.r_state), 32'(ST_SET));

        // start with a zero preset is ignored, and the simultaneous inc is dropped
        press(1'b1, 1'b0, 1'b1);
        check_value("zero_start.running", 32'(bus_if.running), 32'd0);
        check_value("zero_start.state", 32'(dut.r_state), 32'(ST_SET));
        check_disp("zero_start", 0, 0, 0);

        for (int k = 0; k < 3; k++) press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) press(1'b0, 1'b0, 1'b1);
        check_disp("preset_3_5", 3, 5, 1);
        check_value("preset_3_5.state", 32'(dut.r_state), 32'(ST_SET));

        // 00:01 to alarm
        do_reset();
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check_disp("preset_0_1", 0, 1, 1);
        press(1'b1, 1'b0, 1'b0);
        check_value("run1.running", 32'(bus_if.running), 32'd1);
        check_disp("run1.start", 1, 0, 0);
        wait_clk(3);
        check_disp("run1.pre_tick", 1, 0, 0);
        wait_clk(1);
        check_disp("run1.first_tick", 0, 59, 0);
        wait_clk(395);
        check_disp("run1.last_cs", 0, 1, 0);
        check_value("run1.state_399", 32'(dut.r_state), 32'(ST_RUN));
        wait_clk(1);
        check_value("run1.state_400", 32'(dut.r_state), 32'(ST_ALARM));
        check_value("run1.alarm_400", 32'(bus_if.alarm), 32'd0);
        check_value("run1.running_400", 32'(bus_if.running), 32'd0);
        check_disp("run1.zero", 0, 0, 0);
        for (int k = 1; k <= 24; k++) begin
            wait_clk(1);
`ifdef COUNTDOWN_ALARM_BLINK_EN
            exp_alarm = (((k - 1) / 8) % 2 == 0) ? 1 : 0;
            exp_dot   = exp_alarm;
`else
            exp_alarm = 1;
            exp_dot   = 0;
`endif
            check_value("alarm.level", 32'(bus_if.alarm), 32'(exp_alarm));
            check_value("alarm.dot", 32'(bus_if.led_dot), 32'(exp_dot));
        end
        press(1'b1, 1'b0, 1'b0);
        check_value("ack.alarm", 32'(bus_if.alarm), 32'd0);
        check_value("ack.state", 32'(dut.r_state), 32'(ST_SET));
        check_disp("ack", 0, 1, 1);

        // seconds wrap 59 -> 0, then build 01:00
        for (int k = 0; k < 58; k++) press(1'b0, 1'b0, 1'b1);
        check_disp("ss_59", 0, 59, 1);
        press(1'b0, 1'b0, 1'b1);
        check_disp("ss_wrap", 0, 0, 1);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check_disp("preset_1_0", 1, 0, 0);

        press(1'b1, 1'b0, 1'b0);
        check_disp("run2.start", 1, 0, 1);
        wait_clk(3);
        check_disp("run2.pre_tick", 1, 0, 1);
        wait_clk(1);
        check_disp("run2.tick1", 59, 59, 0);
        wait_clk(12);
        check_disp("run2.tick4", 59, 59, 0);
        wait_clk(154);
        check_disp("run2.cc58", 59, 58, 0);

        // pause with 3 of 4 prescaler counts used
        press(1'b1, 1'b0, 1'b0);
        check_value("pause.running", 32'(bus_if.running), 32'd0);
        check_disp("pause.entry", 59, 58, 0);
        wait_clk(100);
        check_disp("pause.held", 59, 58, 0);
        check_value("pause.state", 32'(dut.r_state), 32'(ST_PAUSE));
        press(1'b1, 1'b0, 1'b0);
        check_value("resume.running", 32'(bus_if.running), 32'd1);
        check_disp("resume.edge", 59, 58, 0);
        wait_clk(1);
        check_disp("resume.first_tick", 59, 57, 0);
        wait_clk(4);
        check_disp("resume.second_tick", 59, 56, 0);

        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check_value("abort.state", 32'(dut.r_state), 32'(ST_SET));
        check_value("abort.running", 32'(bus_if.running), 32'd0);
        check_disp("abort", 1, 0, 0);

        // reset in the middle of a run
        press(1'b1, 1'b0, 1'b0);
        wait_clk(10);
        check_value("run3.running", 32'(bus_if.running), 32'd1);
        reset = 1'b1;
        wait_clk(1);
        check_disp("midreset", 0, 0, 0);
        check_value("midreset.alarm", 32'(bus_if.alarm), 32'd0);
        check_value("midreset.running", 32'(bus_if.running), 32'd0);
        check_value("midreset.state", 32'(dut.r_state), 32'(ST_SET));
        reset = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        check_value("postreset.running", 32'(bus_if.running), 32'd0);
        check_disp("postreset", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Count-down companion to the stopwatch timer: the user sets a minutes/seconds preset with the buttons, starts it, and the block decrements MM:SS:CC at centisecond rate to zero, then raises an alarm. It sits beside the stopwatch between the debounced button front end and the two 6-bit LED number drivers. It reuses the same display convention as the stopwatch: MM:SS while minutes are nonzero, SS:CC otherwise.

## Interface
- TICK_DIV, 5000, clock cycles per centisecond tick (≥2)
- BLINK_CS, 50, centiseconds per alarm blink half-period (used only with blink enabled)
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- btn_start  in  1  single-cycle pulse, debounced upstream: start/pause/acknowledge
- btn_field  in  1  single-cycle pulse: toggle edited field (SET), abort (PAUSE), acknowledge (ALARM)
- btn_inc  in  1  single-cycle pulse: increment edited field (SET only)
- led_num0  out  6  left display value (0..59)
- led_num1  out  6  right display value (0..59)
- led_dot  out  1  SET: edited field (0 = minutes, 1 = seconds); otherwise 1 when minutes > 0
- alarm  out  1  alarm indicator
- running  out  1  high in RUN

## Operation
- States: SET, RUN, PAUSE, ALARM. Reset → SET, preset = 00:00, count = 00:00:00, field = minutes, prescaler = 0.
- Button priority within one cycle: btn_start > btn_field > btn_inc. Lower-priority pulses in the same cycle are dropped.
- SET:
  - btn_inc increments the selected preset field, wrapping 59 → 0. Count mirrors the preset with CC = 0.
  - btn_field toggles the field.
  - btn_start → RUN if the preset is nonzero; otherwise ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. At the terminal count it issues a tick and wraps to 0.
  - Each tick decrements the count with a borrow chain: CC 0 → 99 borrows from SS; SS 0 → 59 borrows from MM.
  - btn_start → PAUSE, with prescaler and count held.
- PAUSE:
  - btn_start → RUN, resuming the prescaler from its held value.
  - btn_field → SET, reloading count from the preset and clearing the prescaler.
- ALARM:
  - Entered on the tick that makes the count 00:00:00.
  - btn_start or btn_field → SET, reloading the preset and clearing the prescaler. btn_inc is ignored.
- Display:
  - SET or minutes > 0: led_num0 = MM, led_num1 = SS.
  - Otherwise: led_num0 = SS, led_num1 = CC.
  - In ALARM both display 0.
- CC range is 0..99. It fits in 7 bits internally, but the 6-bit output only ever carries CC in SS:CC mode, so CC is clamped: led_num1 = min(CC, 59). This is documented, intentional saturation.

## Timing
- All outputs are registered; each changes one clock after the causing pulse or tick.
- RUN latency: the first tick occurs TICK_DIV clocks after the btn_start cycle. A preset of N seconds reaches ALARM after N·100·TICK_DIV clocks.
- The zero-reaching tick and the state change to ALARM are the same edge. alarm rises on the following edge.
- btn_start arriving on a tick cycle: the tick's decrement is applied and the state moves to PAUSE on the same edge.
- Reset mid-operation wins over every other input and returns all outputs to their reset values: led_num0 = led_num1 = 0, led_dot = 0, alarm = 0, running = 0.

## Configuration
- COUNTDOWN_ALARM_BLINK_EN defined:
  - In ALARM the prescaler keeps running.
  - alarm toggles every BLINK_CS ticks, starting high.
  - led_dot mirrors alarm.
- COUNTDOWN_ALARM_BLINK_EN undefined:
  - alarm is steady high in ALARM.
  - The prescaler is frozen in ALARM.
  - led_dot = 0 in ALARM.
  - No blink counter is built.

## Structure
- Package countdown_pkg holds:
  - the state enum (SET, RUN, PAUSE, ALARM)
  - the field enum
  - constants UNIT_MAX = 59 and CS_MAX = 99
- Sub-module countdown_chain holds:
  - the MM:SS:CC registers
  - load-from-preset
  - decrement-with-borrow
  - the is_zero flag
- The top level holds the FSM, prescaler, preset registers, blink counter and display mux.

## Test plan
Bench uses TICK_DIV = 4 and BLINK_CS = 2.
- Reset, 3× btn_inc, btn_field, 5× btn_inc → led_num0 = 3, led_num1 = 5, led_dot = 1, state SET.
- Preset 00:01, btn_start → running = 1. After 400 clocks: ALARM, count 00:00:00, and alarm rises 1 clock later.
- Preset 01:00, btn_start, run 4 ticks → led_num0 = 59, led_num1 = 59 (SS:CC mode, CC = 96 clamped), led_dot = 0.
- RUN, btn_start, wait 100 clocks (count unchanged), btn_start → decrements resume; the first tick comes after the held remainder.
- PAUSE, btn_field → SET, with the display back at the preset.
- btn_start with preset 00:00 → stays SET.
- ALARM:
  - Blink build: alarm toggles every 8 clocks.
  - Non-blink build: alarm is steady.
  - btn_start in either build → SET, preset restored, alarm = 0 next clock.
- Reset asserted mid-RUN → next clock all outputs 0, state SET.
